// File: rtl/data_mem_if.sv
// Load/store unit between the core memory port and a word-addressed request/grant data bus.
// Optional bus watchdog enabled by defining DMEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module data_mem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic        we_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        misalign_q;
  logic        buserr_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;

  logic        issue_s;
  logic        start_s;
  logic        timeout_s;
  logic        unused_ok;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lane[0];
      2'b10:   is_misaligned = (lane != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   lane_be = 4'b0001 << lane;
      2'b01:   lane_be = 4'b0011 << lane;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] lane,
                                             input logic [31:0] rd);
    logic [31:0] shifted;
    shifted = rd >> {lane, 3'b000};
    case (size)
      2'b00:   lane_rdata = {24'd0, shifted[7:0]};
      2'b01:   lane_rdata = {16'd0, shifted[15:0]};
      default: lane_rdata = rd;
    endcase
  endfunction

  assign issue_s   = (state_q == IDLE) && (MemRead || MemWrite);
  assign start_s   = issue_s && !is_misaligned(funct3[1:0], Mem_WrAddr[1:0]);
  assign unused_ok = ^{funct3[2], TIMEOUT_W[0]};

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Watchdog: restarts on every bus issue, counts while the transfer is outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (start_s) begin
      cnt_q <= '0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign timeout_s = (cnt_q == CNT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Stall is combinational in IDLE so the PC never advances on the issue cycle.
  assign Stall = issue_s || (state_q == REQ) || (state_q == WAIT);

  // Transfer FSM with all bus and result outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      rdata_q     <= 32'd0;
      misalign_q  <= 1'b0;
      buserr_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'd0;
    end else begin
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue_s) begin
            we_q   <= MemWrite;
            lane_q <= Mem_WrAddr[1:0];
            size_q <= funct3[1:0];
            if (start_s) begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= MemWrite;
              bus_addr_q  <= {Mem_WrAddr[31:2], 2'b00};
              bus_be_q    <= lane_be(funct3[1:0], Mem_WrAddr[1:0]);
              bus_wdata_q <= lane_wdata(funct3[1:0], Mem_WrData);
              state_q     <= REQ;
            end else begin
              misalign_q <= 1'b1;
              if (!MemWrite) begin
                rdata_q <= 32'd0;
              end
              state_q <= DONE;
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_req_q <= 1'b0;
            state_q   <= we_q ? DONE : WAIT;
          end else if (timeout_s) begin
            bus_req_q <= 1'b0;
            buserr_q  <= 1'b1;
            if (!we_q) begin
              rdata_q <= 32'd0;
            end
            state_q <= DONE;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            rdata_q <= lane_rdata(size_q, lane_q, bus_rdata);
            state_q <= DONE;
          end else if (timeout_s) begin
            buserr_q <= 1'b1;
            rdata_q  <= 32'd0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          bus_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ReadData    = rdata_q;
  assign MisalignErr = misalign_q;
  assign BusErr      = buserr_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_if.sv
// Directed bench for data_mem_if: stores, loads, misalignment, async reset, optional watchdog.
module tb_data_mem_if;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        MisalignErr;
  logic        BusErr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .MisalignErr(MisalignErr),
    .BusErr     (BusErr),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set here apply to the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    MemRead    = rd;
    MemWrite   = wr;
    funct3     = f3;
    Mem_WrAddr = addr;
    Mem_WrData = data;
  endtask

  task automatic no_op();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    no_op();
    funct3 = 3'b000; Mem_WrAddr = 32'd0; Mem_WrData = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #3;
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_stall", Stall, 32'd0);
    chk("rst_busreq", bus_req, 32'd0);
    chk("rst_be", bus_be, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // SB 0x1003, grant after two REQ cycles
    step(); issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5); #1;
    chk("sb_issue_stall", Stall, 32'd1);
    chk("sb_issue_req", bus_req, 32'd0);
    step(); no_op(); #1;
    chk("sb_req", bus_req, 32'd1);
    chk("sb_addr", bus_addr, 32'h0000_1000);
    chk("sb_be", bus_be, 32'h8);
    chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
    chk("sb_we", bus_we, 32'd1);
    chk("sb_stall1", Stall, 32'd1);
    step(); bus_gnt = 1'b1; #1;
    chk("sb_req_hold", bus_req, 32'd1);
    chk("sb_stall2", Stall, 32'd1);
    step(); bus_gnt = 1'b0; #1;
    chk("sb_done_stall", Stall, 32'd0);
    chk("sb_done_req", bus_req, 32'd0);
    chk("sb_done_merr", MisalignErr, 32'd0);

    // LH 0x2002, grant next cycle, stray rvalid in REQ, rvalid one cycle after grant
    step(); issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0); #1;
    chk("lh_issue_stall", Stall, 32'd1);
    step(); no_op(); bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    chk("lh_addr", bus_addr, 32'h0000_2000);
    chk("lh_be", bus_be, 32'hC);
    chk("lh_we", bus_we, 32'd0);
    step(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBEEF_1234; #1;
    chk("lh_wait_req", bus_req, 32'd0);
    chk("lh_wait_stall", Stall, 32'd1);
    step(); bus_rvalid = 1'b0; bus_rdata = 32'd0; #1;
    chk("lh_done_stall", Stall, 32'd0);
    chk("lh_data", ReadData, 32'h0000_BEEF);
    step(); #1;
    chk("lh_data_hold", ReadData, 32'h0000_BEEF);

    // LB 0x5001 with a slow grant and slow rvalid
    issue(1'b1, 1'b0, 3'b100, 32'h0000_5001, 32'd0);
    step(); no_op(); #1;
    chk("lb_be", bus_be, 32'h2);
    step(); bus_gnt = 1'b1; #1;
    step(); bus_gnt = 1'b0; #1;
    step(); bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344; #1;
    chk("lb_wait_stall", Stall, 32'd1);
    step(); bus_rvalid = 1'b0; #1;
    chk("lb_data", ReadData, 32'h0000_0033);
    chk("lb_done_stall", Stall, 32'd0);

    // LW 0x3001 misaligned: trapped locally
    step(); issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0); #1;
    chk("lw_mis_issue_stall", Stall, 32'd1);
    step(); no_op(); #1;
    chk("lw_mis_req", bus_req, 32'd0);
    chk("lw_mis_pulse", MisalignErr, 32'd1);
    chk("lw_mis_data", ReadData, 32'd0);
    chk("lw_mis_stall", Stall, 32'd0);
    step(); #1;
    chk("lw_mis_pulse_end", MisalignErr, 32'd0);
    chk("lw_mis_req2", bus_req, 32'd0);

    // MemRead and MemWrite together: store wins
    step(); issue(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678); #1;
    step(); no_op(); bus_gnt = 1'b1; #1;
    chk("sw_we", bus_we, 32'd1);
    chk("sw_be", bus_be, 32'hF);
    chk("sw_wdata", bus_wdata, 32'h1234_5678);
    chk("sw_addr", bus_addr, 32'h0000_0040);
    step(); bus_gnt = 1'b0; #1;
    chk("sw_done_stall", Stall, 32'd0);
    chk("sw_readdata_kept", ReadData, 32'd0);

    // SH 0x0006: upper half lanes
    step(); issue(1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h0000_CAFE); #1;
    step(); no_op(); bus_gnt = 1'b1; #1;
    chk("sh_be", bus_be, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hCAFE_CAFE);
    chk("sh_addr", bus_addr, 32'h0000_0004);
    step(); bus_gnt = 1'b0; #1;

    // LW 0x80, async reset while waiting for read data
    step(); issue(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'd0); #1;
    step(); no_op(); bus_gnt = 1'b1; #1;
    step(); bus_gnt = 1'b0; #1;
    chk("rstw_wait_stall", Stall, 32'd1);
    #2; reset = 1'b0; #1;
    chk("rstw_req", bus_req, 32'd0);
    chk("rstw_stall", Stall, 32'd0);
    chk("rstw_readdata", ReadData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(); bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF; #1;
    chk("rstw_late_stall", Stall, 32'd0);
    step(); bus_rvalid = 1'b0; #1;
    chk("rstw_late_data", ReadData, 32'd0);
    chk("rstw_late_req", bus_req, 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // SW 0x10 with no grant: watchdog of 4 cycles
    step(); issue(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0001); #1;
    step(); no_op(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("to_stall", Stall, 32'd1);
      chk("to_buserr_low", BusErr, 32'd0);
      step(); #1;
    end
    chk("to_stall_last", Stall, 32'd1);
    step(); #1;
    chk("to_buserr", BusErr, 32'd1);
    chk("to_stall_rel", Stall, 32'd0);
    chk("to_req_drop", bus_req, 32'd0);
    step(); #1;
    chk("to_buserr_end", BusErr, 32'd0);
`else
    chk("buserr_tied", BusErr, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
